// File: rtl/gfx_shader_loop_fifo_pkg.sv
// Shared types and sizing for the shader loop-back FIFO.
// group_id is the scheduler's warp-group handle carried around the loop.
package gfx_shader_loop_fifo_pkg;

    localparam int GROUP_ID_W = 6;

    typedef logic [GROUP_ID_W-1:0] group_id;

    localparam int LOOP_FIFO_DEPTH = 16;

endpackage

// File: rtl/gfx_shader_loop_fifo.sv
// Loop-back FIFO returning groups from writeback to the front-end scheduler.
// Optional macro GFX_LOOP_FIFO_BYPASS_EN: empty-queue groups skip storage combinationally.
module gfx_shader_loop_fifo
    import gfx_shader_loop_fifo_pkg::*;
#(
    parameter int DEPTH = LOOP_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  group_id                  in_group,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output group_id                  out_group,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("gfx_shader_loop_fifo: DEPTH must be a power of two and at least 2");
    end

    group_id          mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic accept;
    logic pop;
    logic push;
    logic drop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    // A group arriving in a flush cycle is thrown away with the rest of the queue.
    assign accept = in_valid & ~flush;

`ifdef GFX_LOOP_FIFO_BYPASS_EN
    logic bypass;

    assign bypass    = empty & accept;
    assign out_valid = ~empty | bypass;
    assign out_group = bypass ? in_group : mem[rptr];
    assign pop       = ~empty & out_ready;
    // A bypassed group taken by the scheduler this cycle never enters storage.
    assign push      = accept & ~(bypass & out_ready) & (~full | pop);
`else
    assign out_valid = ~empty;
    assign out_group = mem[rptr];
    assign pop       = out_valid & out_ready;
    assign push      = accept & (~full | pop);
`endif

    assign drop     = accept & full & ~pop;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr       <= '0;
            wptr       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush) begin
                rptr    <= '0;
                wptr    <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage is deliberately left unreset; out_group is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_group;
        end
    end

    logic in_group_queued;

    always_comb begin
        in_group_queued = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (mem[rptr + PTR_W'(i)] == in_group)) begin
                in_group_queued = 1'b1;
            end
        end
    end

    // Each group has at most one outstanding trip around the loop.
    a_single_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) in_valid |-> !in_group_queued
    ) else $error("gfx_shader_loop_fifo: group %0d returned while already queued", in_group);

endmodule

// File: tb/tb_gfx_shader_loop_fifo.sv
// Directed self-checking bench for gfx_shader_loop_fifo.
// Expectations follow GFX_LOOP_FIFO_BYPASS_EN when the build defines it.
module tb_gfx_shader_loop_fifo;
    import gfx_shader_loop_fifo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    group_id     in_group;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    group_id     out_group;
    logic [4:0]  count;
    logic        overflow;

    int vectors;
    int miscompares;

    gfx_shader_loop_fifo #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_group  (in_group),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_group (out_group),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        #1;
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        group_id exp [3];
        group_id got [$];
        exp[0] = 6'd3;
        exp[1] = 6'd7;
        exp[2] = 6'd1;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            out_ready = 1'b1;
            in_valid  = (c < 3);
            if (c < 3) in_group = exp[c];
            #1;
            if (out_valid) got.push_back(out_group);
        end
        vectors++;
        if (got.size() !== 3) begin miscompares++; $display("[TB] FAIL order_pop_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= got.size()) begin
                miscompares++; $display("[TB] FAIL order_group%0d: got none expected %0d", i, exp[i]);
            end else if (got[i] !== exp[i]) begin
                miscompares++; $display("[TB] FAIL order_group%0d: got %0d expected %0d", i, got[i], exp[i]);
            end
        end
        next_cycle();
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL order_count_end: got %0d expected 0", count); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL order_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow_and_full_pass();
        group_id e;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            in_valid = 1'b1;
            in_group = group_id'(20 + i);
        end
        next_cycle();
        in_valid = 1'b1;
        in_group = 6'd50;
        #1;
        vectors++;
        if (count !== 5'd16) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 16", count); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_overflow_yet: got %b expected 0", overflow); end
        next_cycle();
        in_valid  = 1'b1;
        in_group  = 6'd9;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (count !== 5'd16) begin miscompares++; $display("[TB] FAIL drop_count: got %0d expected 16", count); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_overflow: got %b expected 1", overflow); end
        vectors++;
        if (out_group !== 6'd20) begin miscompares++; $display("[TB] FAIL drop_head: got %0d expected 20", out_group); end
        next_cycle();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd16) begin miscompares++; $display("[TB] FAIL full_push_pop_count: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? group_id'(21 + i) : 6'd9;
            vectors++;
            if ((out_valid !== 1'b1) || (out_group !== e)) begin
                miscompares++;
                $display("[TB] FAIL drain%0d: got valid=%b group=%0d expected valid=1 group=%0d", i, out_valid, out_group, e);
            end
            next_cycle();
            #1;
        end
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL drain_count: got %0d expected 0", count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            in_valid = 1'b1;
            in_group = group_id'(40 + i);
        end
        next_cycle();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_group = 6'd45;
        #1;
        vectors++;
        if (count !== 5'd5) begin miscompares++; $display("[TB] FAIL preflush_count: got %0d expected 5", count); end
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_overflow_sticky: got %b expected 1", overflow); end
        next_cycle();
        in_valid = 1'b1;
        in_group = 6'd2;
        next_cycle();
        in_valid = 1'b0;
        #1;
        vectors++;
        if ((out_valid !== 1'b1) || (out_group !== 6'd2)) begin
            miscompares++; $display("[TB] FAIL post_flush_group: got valid=%b group=%0d expected valid=1 group=2", out_valid, out_group);
        end
        vectors++;
        if (count !== 5'd1) begin miscompares++; $display("[TB] FAIL post_flush_count: got %0d expected 1", count); end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL post_flush_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            in_valid = 1'b1;
            in_group = group_id'(60 + i);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd4) begin miscompares++; $display("[TB] FAIL prereset_count: got %0d expected 4", count); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL async_reset_count: got %0d expected 0", count); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_overflow: got %b expected 0", overflow); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        in_group  = 6'd4;
        out_ready = 1'b1;
        #1;
`ifdef GFX_LOOP_FIFO_BYPASS_EN
        vectors++;
        if ((out_valid !== 1'b1) || (out_group !== 6'd4)) begin
            miscompares++; $display("[TB] FAIL bypass_same_cycle: got valid=%b group=%0d expected valid=1 group=4", out_valid, out_group);
        end
`else
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL no_bypass_same_cycle: got %b expected 0", out_valid); end
`endif
        next_cycle();
        in_valid = 1'b0;
        #1;
`ifdef GFX_LOOP_FIFO_BYPASS_EN
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bypass_next_valid: got %b expected 0", out_valid); end
`else
        vectors++;
        if ((out_valid !== 1'b1) || (out_group !== 6'd4)) begin
            miscompares++; $display("[TB] FAIL first_push_next_cycle: got valid=%b group=%0d expected valid=1 group=4", out_valid, out_group);
        end
        vectors++;
        if (count !== 5'd1) begin miscompares++; $display("[TB] FAIL first_push_count: got %0d expected 1", count); end
`endif
        next_cycle();
        #1;
        vectors++;
        if (count !== 5'd0) begin miscompares++; $display("[TB] FAIL bypass_final_count: got %0d expected 0", count); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_group    = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        $display("[TB] starting gfx_shader_loop_fifo directed tests");
        test_reset();
        test_in_order();
        test_overflow_and_full_pass();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
